// File: rtl/decoder_scan_if.sv
// decoder_scan_if: control and select-output bundle of decoder_scan.
// The controller side (master) drives the enable, mode and code inputs.
// The decoder side (slave) returns the one-hot select, the current code and the wrap pulse.
interface decoder_scan_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic             load;
  logic [SEL_W-1:0] scan_last;
  logic [OUT_W-1:0] y;
  logic [SEL_W-1:0] cur_sel;
  logic             wrap;

  modport master (
    output en, mode, sel_in, load, scan_last,
    input  y, cur_sel, wrap
  );

  modport slave (
    input  en, mode, sel_in, load, scan_last,
    output y, cur_sel, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot select generator for display
// digit/row multiplexing. In direct mode it decodes a strobed code. In auto-scan
// mode it steps channels 0..scan_last, holding each channel for DWELL cycles.
// Defining DEC_BLANK_EN builds an all-off gap of BLANK_CYC cycles between
// scan channels. Without DEC_BLANK_EN the channels switch back to back.
//
// state  | meaning
// IDLE   | disabled; y off, channel code and dwell count frozen
// DIRECT | y shows the last latched code, load strobes a new one
// SCAN   | dwell counter running, channel advances at dwell end
// BLANK  | all-off gap after each dwell (DEC_BLANK_EN builds only)
module decoder_scan #(
  parameter int SEL_W     = 3,
  parameter int DWELL     = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  decoder_scan_if.slave bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  if (DWELL < 1) begin : g_bad_dwell
    $error("decoder_scan: DWELL must be >= 1");
  end
  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("decoder_scan: BLANK_CYC must be >= 1");
  end

`ifdef DEC_BLANK_EN
  localparam int BCNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN, ST_BLANK} state_t;
  logic [BCNT_W-1:0] bcnt_q;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_t;
`endif

  state_t           state_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] y_q;
  logic             wrap_q;

  logic [SEL_W-1:0] next_sel_d;
  logic             next_wrap_d;
  logic             dwell_end_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] code);
    onehot       = '0;
    onehot[code] = 1'b1;
  endfunction

  // Channel that follows the current one. The >= compare makes a scan_last
  // lowered below the current channel wrap at the end of this dwell.
  always_comb begin
    dwell_end_d = (cnt_q == CNT_LAST);
    next_wrap_d = (cur_sel_q >= bus.scan_last);
    next_sel_d  = next_wrap_d ? '0 : cur_sel_q + SEL_W'(1);
  end

  // Mode FSM with registered select outputs; wrap is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_sel_q <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      wrap_q    <= 1'b0;
`ifdef DEC_BLANK_EN
      bcnt_q    <= '0;
`endif
    end else begin
      wrap_q <= 1'b0;
      if (!bus.en) begin
        state_q <= ST_IDLE;
        y_q     <= '0;
      end else begin
        case (state_q)
          ST_DIRECT: begin
            if (bus.mode) begin
              // Entering scan always restarts from channel 0 with no wrap pulse.
              state_q   <= ST_SCAN;
              cur_sel_q <= '0;
              cnt_q     <= '0;
              y_q       <= onehot('0);
            end else if (bus.load) begin
              cur_sel_q <= bus.sel_in;
              y_q       <= onehot(bus.sel_in);
            end
          end
`ifdef DEC_BLANK_EN
          ST_BLANK: begin
            if (!bus.mode) begin
              state_q <= ST_DIRECT;
              cnt_q   <= '0;
              y_q     <= onehot(cur_sel_q);
            end else if (bcnt_q == BCNT_LAST) begin
              state_q <= ST_SCAN;
              cnt_q   <= '0;
              y_q     <= onehot(cur_sel_q);
            end else begin
              bcnt_q <= bcnt_q + BCNT_W'(1);
            end
          end
`endif
          default: begin
            // IDLE and SCAN share the scan step. This way, resuming from IDLE
            // continues the dwell that was frozen when en dropped.
            if (!bus.mode) begin
              state_q <= ST_DIRECT;
              y_q     <= onehot(cur_sel_q);
              if (state_q == ST_SCAN) begin
                cnt_q <= '0;
              end
            end else begin
              state_q <= ST_SCAN;
              if (dwell_end_d) begin
                cnt_q     <= '0;
                cur_sel_q <= next_sel_d;
                wrap_q    <= next_wrap_d;
`ifdef DEC_BLANK_EN
                state_q   <= ST_BLANK;
                bcnt_q    <= '0;
                y_q       <= '0;
`else
                y_q       <= onehot(next_sel_d);
`endif
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                y_q   <= onehot(cur_sel_q);
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: vector table, directed scan sequences and randomized
// traffic against a behavioural model of decoder_scan (SEL_W=3, DWELL=4).
module tb_decoder_scan;
  localparam int SEL_W     = 3;
  localparam int DWELL     = 4;
  localparam int BLANK_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(SEL_W)) bus ();

  decoder_scan #(.SEL_W(SEL_W), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: on/off, scanning flag, channel, dwell edges left, gap left.
  bit m_on, m_scan, m_wrap;
  int m_ch, m_left, m_gap;

  task automatic model_tick(input int last);
    m_left--;
    if (m_left == 0) begin
      m_left = DWELL;
      if (m_ch >= last) begin
        m_ch   = 0;
        m_wrap = 1'b1;
      end else begin
        m_ch++;
      end
`ifdef DEC_BLANK_EN
      m_gap = BLANK_CYC;
`endif
    end
  endtask

  task automatic model_edge(input bit r, e, m, l, input int s, last);
    m_wrap = 1'b0;
    if (r) begin
      m_on = 0; m_scan = 0; m_ch = 0; m_left = DWELL; m_gap = 0;
    end else if (!e) begin
      m_on  = 0;
      m_gap = 0;
    end else if (!m_on) begin
      m_on   = 1;
      m_scan = m;
      if (m) model_tick(last);
    end else if (!m_scan) begin
      if (m) begin
        m_scan = 1; m_ch = 0; m_left = DWELL;
      end else if (l) begin
        m_ch = s;
      end
    end else if (!m) begin
      m_scan = 0; m_left = DWELL; m_gap = 0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      model_tick(last);
    end
  endtask

  task automatic cyc(input bit r, e, m, l, input logic [2:0] s, input logic [2:0] sl);
    rst           = r;
    bus.en        = e;
    bus.mode      = m;
    bus.load      = l;
    bus.sel_in    = s;
    bus.scan_last = sl;
    @(posedge clk);
    model_edge(r, e, m, l, int'(s), int'(sl));
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] ey, input int ecs, input bit ew);
    chk({name, " y"}, 32'(bus.y), 32'(ey));
    chk({name, " cur_sel"}, 32'(bus.cur_sel), 32'(ecs));
    chk({name, " wrap"}, 32'(bus.wrap), 32'(ew));
  endtask

  typedef struct {
    bit         r, e, m, l;
    logic [2:0] sel, last;
    logic [7:0] y;
    int         cs;
    bit         w;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] ey;
    int ecs;
    bit mode_r;
    logic [2:0] last_r;

    //            rst en mode load sel   last    y      cs wrap
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 8'h00, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 8'h00, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 8'h01, 0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd7, 8'h20, 5, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd7, 8'h20, 5, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd7, 8'h20, 5, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd7, 8'h80, 7, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 8'h80, 7, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd7, 8'h00, 7, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd7, 8'h80, 7, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 3'd7, 8'h01, 0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].l, vecs[i].sel, vecs[i].last);
      chk_out($sformatf("vec%0d", i), vecs[i].y, vecs[i].cs, vecs[i].w);
    end

`ifndef DEC_BLANK_EN
    // Full scan from channel 0 (started by vec10); load must be ignored.
    for (int j = 1; j <= 44; j++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 3'd7);
      chk_out($sformatf("scan%0d", j), 8'(1 << ((j / 4) % 8)), (j / 4) % 8, j == 32);
    end
    // Reset while channel 3 is showing.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
    chk_out("rst_mid", 8'h00, 0, 1'b0);

    // Short scan to channel 2, then shrink scan_last to 0 while channel 2 shows.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2);
    chk_out("short_dir", 8'h01, 0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2);
    chk_out("short0", 8'h01, 0, 1'b0);
    for (int j = 1; j <= 32; j++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2);
      chk_out($sformatf("short%0d", j), 8'(1 << ((j / 4) % 3)), (j / 4) % 3, (j % 12) == 0);
    end
    for (int j = 33; j <= 45; j++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
      chk_out($sformatf("shrink%0d", j), (j < 36) ? 8'h04 : 8'h01, (j < 36) ? 2 : 0,
              (j >= 36) && ((j % 4) == 0));
    end

    // Enable gating: two cycles of channel 2, ten disabled, then resume.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
    for (int j = 1; j <= 9; j++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
    chk_out("gate_pre", 8'h04, 2, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 3'd7);
      chk_out($sformatf("gate_off%0d", k), 8'h00, 2, 1'b0);
    end
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
      ey  = (k < 2) ? 8'h04 : (k < 6) ? 8'h08 : 8'h10;
      ecs = (k < 2) ? 2 : (k < 6) ? 3 : 4;
      chk_out($sformatf("gate_on%0d", k), ey, ecs, 1'b0);
    end
`else
    // Blanked scan: four cycles per channel, then a two-cycle all-off gap.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
    chk_out("blank0", 8'h01, 0, 1'b0);
    for (int j = 1; j <= 48; j++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
      ey  = ((j % 6) < 4) ? 8'(1 << ((j / 6) % 8)) : 8'h00;
      ecs = ((j % 6) < 4) ? (j / 6) % 8 : ((j / 6) + 1) % 8;
      chk_out($sformatf("blank%0d", j), ey, ecs, j == 46);
    end
`endif

    // Randomized traffic against the model.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7);
    mode_r = 1'b0;
    last_r = 3'd7;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) mode_r = ~mode_r;
      if ($urandom_range(0, 39) == 0) last_r = 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, mode_r,
          $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), last_r);
      ey = (m_on && m_gap == 0) ? 8'(1 << m_ch) : 8'h00;
      chk_out($sformatf("rand%0d", n), ey, m_ch, m_wrap);
      chk($sformatf("rand%0d onehot", n), 32'($countones(bus.y) <= 1), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
